// File: rtl/lzrw1_group_packer.sv
// Groups LZRW1 literal/copy items and streams each group as control bytes followed by item bytes.
// Flow-controlled on both sides; flush emits a partial group and pulses done.
module lzrw1_group_packer #(
    parameter int unsigned GROUP_ITEMS = 16,
    parameter int unsigned OFFSET_W    = 12,
    parameter int unsigned LEN_W       = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_copy,
    input  logic [7:0]          in_literal,
    input  logic [OFFSET_W-1:0] in_offset,
    input  logic [LEN_W-1:0]    in_len,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_byte,
    output logic                out_last,
    output logic                done,
    output logic [CNT_W-1:0]    group_count,
    output logic [CNT_W-1:0]    byte_count
);

    localparam int unsigned CTRL_BYTES = GROUP_ITEMS / 8;
    localparam int unsigned BUF_BYTES  = 2 * GROUP_ITEMS;
    localparam int unsigned IDX_W      = $clog2(BUF_BYTES);
    localparam int unsigned PTR_W      = $clog2(BUF_BYTES + 1);
    localparam int unsigned ITEM_W     = $clog2(GROUP_ITEMS + 1);

    typedef enum logic [1:0] {StFill, StEmitCtrl, StEmitData, StDone} packStateT;

    packStateT               state, stateNext;
    logic [ITEM_W-1:0]       itemCount, itemCountNext, itemsAfter;
    logic [PTR_W-1:0]        wrPtr, wrPtrNext;
    logic [PTR_W-1:0]        rdPtr, rdPtrNext;
    logic [GROUP_ITEMS-1:0]  ctrl, ctrlNext;
    logic                    flushPending, flushPendingNext;
    logic                    lastGroup, lastGroupNext;
    logic [CNT_W-1:0]        groupCnt, groupCntNext;
    logic [CNT_W-1:0]        byteCnt, byteCntNext;
    logic                    started;
    logic [7:0]              byteBuf [BUF_BYTES];

    logic                    accept, handshake, flushNow, lastData;
    logic [7:0]              ctrlByte, dataByte, copyHi;
    logic [IDX_W-1:0]        wrIdx, wrIdxHi, rdIdx;

    assign accept    = in_valid & in_ready;
    assign handshake = out_valid & out_ready;
    assign flushNow  = flushPending | flush;
    assign lastData  = (rdPtr == wrPtr - PTR_W'(1));
    assign copyHi    = {in_offset[OFFSET_W-1:8], in_len};
    assign wrIdx     = wrPtr[IDX_W-1:0];
    assign wrIdxHi   = wrIdx + IDX_W'(1);
    assign rdIdx     = rdPtr[IDX_W-1:0];
    assign dataByte  = byteBuf[rdIdx];

    always_comb begin
        ctrlByte = 8'h00;
        for (int b = 0; b < int'(CTRL_BYTES); b++) begin
            if (rdPtr == PTR_W'(b)) ctrlByte = ctrl[b*8 +: 8];
        end
    end

    // started holds in_ready low until the first clock after reset releases
    assign in_ready    = started & (state == StFill) & ~flushPending;
    assign out_valid   = (state == StEmitCtrl) | (state == StEmitData);
    assign out_byte    = (state == StEmitCtrl) ? ctrlByte :
                         (state == StEmitData) ? dataByte : 8'h00;
    assign out_last    = (state == StEmitData) & lastGroup & lastData;
    assign done        = (state == StDone);
    assign group_count = groupCnt;
    assign byte_count  = byteCnt;

    always_comb begin
        stateNext        = state;
        itemCountNext    = itemCount;
        itemsAfter       = itemCount;
        wrPtrNext        = wrPtr;
        rdPtrNext        = rdPtr;
        ctrlNext         = ctrl;
        lastGroupNext    = lastGroup;
        groupCntNext     = groupCnt;
        flushPendingNext = flushPending | flush;
        byteCntNext      = handshake ? byteCnt + CNT_W'(1) : byteCnt;

        unique case (state)
            StFill: begin
                if (accept) begin
                    itemsAfter = itemCount + ITEM_W'(1);
                    ctrlNext   = ctrl | (GROUP_ITEMS'(in_is_copy) << itemCount);
                    wrPtrNext  = wrPtr + (in_is_copy ? PTR_W'(2) : PTR_W'(1));
                end
                itemCountNext = itemsAfter;
                rdPtrNext     = '0;
                // A flush coinciding with the final accept still marks this group as the last
                if (itemsAfter == ITEM_W'(GROUP_ITEMS)) begin
                    stateNext     = StEmitCtrl;
                    lastGroupNext = flushNow;
                end else if (flushNow) begin
                    if (itemsAfter != '0) begin
                        stateNext     = StEmitCtrl;
                        lastGroupNext = 1'b1;
                    end else begin
                        stateNext = StDone;
                    end
                end
            end
            StEmitCtrl: begin
                if (handshake) begin
                    if (rdPtr == PTR_W'(CTRL_BYTES - 1)) begin
                        stateNext = StEmitData;
                        rdPtrNext = '0;
                    end else begin
                        rdPtrNext = rdPtr + PTR_W'(1);
                    end
                end
            end
            StEmitData: begin
                if (handshake) begin
                    if (lastData) begin
                        groupCntNext  = groupCnt + CNT_W'(1);
                        ctrlNext      = '0;
                        itemCountNext = '0;
                        wrPtrNext     = '0;
                        rdPtrNext     = '0;
                        lastGroupNext = 1'b0;
                        stateNext     = lastGroup ? StDone : StFill;
                    end else begin
                        rdPtrNext = rdPtr + PTR_W'(1);
                    end
                end
            end
            StDone: begin
                flushPendingNext = flush;
                stateNext        = StFill;
            end
            default: stateNext = StFill;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= StFill;
            itemCount    <= '0;
            wrPtr        <= '0;
            rdPtr        <= '0;
            ctrl         <= '0;
            flushPending <= 1'b0;
            lastGroup    <= 1'b0;
            groupCnt     <= '0;
            byteCnt      <= '0;
            started      <= 1'b0;
        end else begin
            state        <= stateNext;
            itemCount    <= itemCountNext;
            wrPtr        <= wrPtrNext;
            rdPtr        <= rdPtrNext;
            ctrl         <= ctrlNext;
            flushPending <= flushPendingNext;
            lastGroup    <= lastGroupNext;
            groupCnt     <= groupCntNext;
            byteCnt      <= byteCntNext;
            started      <= 1'b1;
        end
    end

    // Payload storage needs no reset; wrPtr governs what is valid
    always_ff @(posedge clock) begin
        if (accept) begin
            if (in_is_copy) begin
                byteBuf[wrIdx]   <= copyHi;
                byteBuf[wrIdxHi] <= in_offset[7:0];
            end else begin
                byteBuf[wrIdx] <= in_literal;
            end
        end
    end

endmodule

// File: tb/tb_lzrw1_group_packer.sv
// Directed bench for lzrw1_group_packer: full groups, copies, stalls, flush, reset and an 8-item
// instance.
module tb_lzrw1_group_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_is_copy, flush, out_ready;
    logic [7:0]  in_literal;
    logic [11:0] in_offset;
    logic [3:0]  in_len;
    logic        in_ready, out_valid, out_last, done;
    logic [7:0]  out_byte;
    logic [15:0] group_count, byte_count;

    logic        in_valid8, in_ready8, out_valid8, out_last8, done8;
    logic [7:0]  in_literal8, out_byte8;
    logic [15:0] group_count8, byte_count8;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0, lastCyc = 0, doneCyc = 0, flushCyc = 0, doneCnt = 0;
    bit          prevStall = 0, validSeen = 0, toggleReady = 0;
    logic [8:0]  prevWord = '0;
    logic [8:0]  gotQ[$];
    logic [8:0]  gotQ8[$];
    logic [7:0]  expQ[$];

    always #5 clock = ~clock;

    lzrw1_group_packer #(.GROUP_ITEMS(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_copy(in_is_copy), .in_literal(in_literal), .in_offset(in_offset),
        .in_len(in_len), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last), .done(done),
        .group_count(group_count), .byte_count(byte_count)
    );

    lzrw1_group_packer #(.GROUP_ITEMS(8)) dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_is_copy(1'b0), .in_literal(in_literal8), .in_offset(12'h000),
        .in_len(4'h0), .flush(1'b0), .out_valid(out_valid8), .out_ready(1'b1),
        .out_byte(out_byte8), .out_last(out_last8), .done(done8),
        .group_count(group_count8), .byte_count(byte_count8)
    );

    task automatic checkVal(input string tag, input int unsigned got, input int unsigned want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            if (out_valid) checkVal("ready_low_in_emit", in_ready, 0);
            if (prevStall && out_valid) checkVal("stall_hold", {out_last, out_byte}, prevWord);
            prevStall = out_valid && !out_ready;
            prevWord  = {out_last, out_byte};
            if (out_valid) validSeen = 1;
            if (out_valid && out_ready) begin
                gotQ.push_back({out_last, out_byte});
                if (out_last) lastCyc = cyc;
            end
            if (out_valid8) gotQ8.push_back({out_last8, out_byte8});
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (flush) flushCyc = cyc;
        end
    end

    // Toggles out_ready each cycle while stall testing is enabled
    always @(posedge clock) begin
        #1;
        if (toggleReady) out_ready = ~out_ready;
    end

    task automatic sendItem(input bit eight, input bit isCopy, input logic [7:0] lit,
                            input logic [11:0] off, input logic [3:0] len);
        bit ok = 0;
        @(posedge clock);
        #1;
        if (eight) begin
            in_valid8 = 1; in_literal8 = lit;
        end else begin
            in_valid = 1; in_is_copy = isCopy; in_literal = lit; in_offset = off; in_len = len;
        end
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (eight ? in_ready8 : in_ready) ok = 1;
            @(posedge clock);
            #1;
        end
        in_valid = 0;
        in_valid8 = 0;
        if (!ok) checkVal("send_timeout", 0, 1);
    endtask

    task automatic waitCount(input int n);
        for (int i = 0; i < 500 && gotQ.size() < n; i++) @(negedge clock);
        if (gotQ.size() < n) checkVal("byte_timeout", gotQ.size(), n);
    endtask

    task automatic waitIdle();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) ok = 1;
        end
        if (!ok) checkVal("idle_timeout", 0, 1);
    endtask

    task automatic checkStream(input string tag, input bit lastOnFinal);
        checkVal({tag, "_len"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkVal($sformatf("%s_b%0d", tag, i), gotQ[i][7:0], expQ[i]);
            checkVal($sformatf("%s_l%0d", tag, i), gotQ[i][8],
                     (lastOnFinal && i == expQ.size() - 1) ? 1 : 0);
        end
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic runT1(input string tag);
        for (int i = 0; i < 16; i++) sendItem(0, 0, 8'(i), 12'h000, 4'h0);
        @(negedge clock);
        checkVal({tag, "_latency"}, out_valid, 1);
        expQ.push_back(8'h00);
        expQ.push_back(8'h00);
        for (int i = 0; i < 16; i++) expQ.push_back(8'(i));
        waitCount(18);
        waitIdle();
        checkStream(tag, 0);
    endtask

    task automatic runT2(input string tag);
        sendItem(0, 1, 8'h00, 12'h123, 4'h5);
        for (int i = 0; i < 15; i++) sendItem(0, 0, 8'hAA, 12'h000, 4'h0);
        expQ.push_back(8'h01);
        expQ.push_back(8'h00);
        expQ.push_back(8'h15);
        expQ.push_back(8'h23);
        for (int i = 0; i < 15; i++) expQ.push_back(8'hAA);
        waitCount(19);
        waitIdle();
        checkStream(tag, 0);
    endtask

    initial begin
        reset = 1; in_valid = 0; in_is_copy = 0; in_literal = 0; in_offset = 0; in_len = 0;
        flush = 0; out_ready = 1; in_valid8 = 0; in_literal8 = 0;
        repeat (2) @(negedge clock);
        checkVal("rst_in_ready", in_ready, 0);
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_out_byte", out_byte, 0);
        checkVal("rst_out_last", out_last, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_counts", {group_count, byte_count}, 0);
        @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        checkVal("ready_before_clk", in_ready, 0);
        @(negedge clock);
        checkVal("ready_after_clk", in_ready, 1);

        runT1("t1");
        checkVal("t1_groups", group_count, 1);
        checkVal("t1_bytes", byte_count, 18);

        runT2("t2");
        checkVal("t2_groups", group_count, 2);
        checkVal("t2_bytes", byte_count, 37);

        toggleReady = 1;
        runT2("t3");
        toggleReady = 0;
        @(posedge clock);
        #2 out_ready = 1;
        checkVal("t3_groups", group_count, 3);
        checkVal("t3_bytes", byte_count, 56);

        doneCnt = 0;
        sendItem(0, 0, 8'h41, 12'h000, 4'h0);
        sendItem(0, 0, 8'h42, 12'h000, 4'h0);
        sendItem(0, 0, 8'h43, 12'h000, 4'h0);
        @(posedge clock);
        #1 flush = 1;
        @(posedge clock);
        #1 flush = 0;
        expQ.push_back(8'h00);
        expQ.push_back(8'h00);
        expQ.push_back(8'h41);
        expQ.push_back(8'h42);
        expQ.push_back(8'h43);
        waitCount(5);
        waitIdle();
        checkStream("t4", 1);
        checkVal("t4_done_once", doneCnt, 1);
        checkVal("t4_done_cycle", doneCyc, lastCyc + 1);
        checkVal("t4_groups", group_count, 4);
        checkVal("t4_bytes", byte_count, 61);

        doneCnt = 0;
        validSeen = 0;
        @(posedge clock);
        #1 flush = 1;
        @(posedge clock);
        #1 flush = 0;
        repeat (5) @(negedge clock);
        checkVal("t5_done_once", doneCnt, 1);
        checkVal("t5_done_cycle", doneCyc, flushCyc + 1);
        checkVal("t5_no_valid", validSeen, 0);
        checkVal("t5_groups", group_count, 4);
        checkVal("t5_bytes", byte_count, 61);
        checkVal("t5_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) sendItem(0, 0, 8'(i), 12'h000, 4'h0);
        waitCount(5);
        @(posedge clock);
        #1 reset = 1;
        #1;
        checkVal("t6_valid", out_valid, 0);
        checkVal("t6_ready", in_ready, 0);
        checkVal("t6_counts", {group_count, byte_count}, 0);
        gotQ.delete();
        gotQ8.delete();
        @(posedge clock);
        #1 reset = 0;
        runT1("t6");
        checkVal("t6_groups", group_count, 1);
        checkVal("t6_bytes", byte_count, 18);

        for (int i = 0; i < 8; i++) sendItem(1, 0, 8'(8'h30 + i), 12'h000, 4'h0);
        for (int i = 0; i < 100 && gotQ8.size() < 9; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        checkVal("g8_len", gotQ8.size(), 9);
        for (int i = 0; i < 9 && i < gotQ8.size(); i++)
            checkVal($sformatf("g8_b%0d", i), gotQ8[i], (i == 0) ? 0 : 8'h30 + i - 1);
        checkVal("g8_groups", group_count8, 1);
        checkVal("g8_bytes", byte_count8, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
